// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch (PC + single-outstanding imem request) and the
//            IF/ID pipeline register feeding the decode/control stage.
// Options  : FETCH_PERF_EN - adds a 32-bit fetch_count output counting valid
//            IF/ID loads.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [31:0]        NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [5:0]        if_id_op,
  output logic [5:0]        if_id_funct
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  localparam logic [ADDR_W-1:0] c_PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(3);

  // ISSUE: request on the bus; WAIT: request accepted, response pending;
  // HOLD: response parked in the skid buffer while decode is stalled.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_drop;
  logic [31:0]         r_buf;
  logic                r_if_valid;
  logic [31:0]         r_if_instr;
  logic [ADDR_W-1:0]   r_if_pc4;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                w_drop_nxt;
  logic [31:0]         w_buf_nxt;
  logic                w_if_valid_nxt;
  logic [31:0]         w_if_instr_nxt;
  logic [ADDR_W-1:0]   w_if_pc4_nxt;
  logic                w_load_en;
  logic [31:0]         w_load_data;

  logic                w_redirect;
  logic [ADDR_W-1:0]   w_redir_target;
  logic [ADDR_W-1:0]   w_redir_pc;
  logic [ADDR_W-1:0]   w_pc_plus4;
  logic                w_can_load;

  assign w_redirect     = jump | branch_taken;
  // Jump outranks branch when both fire in the same cycle.
  assign w_redir_target = jump ? jump_target : branch_target;
  assign w_redir_pc     = w_redir_target & ~c_ALIGN_MASK;
  assign w_pc_plus4     = r_pc + c_PC_STEP;
  // IF/ID may be overwritten if decode is taking its content or it is empty.
  assign w_can_load     = ~stall | ~r_if_valid;

  // Next-state, PC, drop flag, skid buffer and IF/ID next values.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_buf_nxt      = r_buf;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc4_nxt   = r_if_pc4;
    w_load_en      = 1'b0;
    w_load_data    = imem_resp_data;

    if (w_redirect) begin
      // Redirect overrides stall: flush IF/ID, forget any buffered word.
      w_pc_nxt       = w_redir_pc;
      w_if_valid_nxt = 1'b0;
      w_if_instr_nxt = NOP_INSTR;
      w_state_nxt    = S_ISSUE;
      w_drop_nxt     = 1'b0;
      case (r_state)
        S_ISSUE: begin
          // A request accepted this very cycle is now stale in flight.
          if (imem_req_ready) begin
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end
        S_WAIT: begin
          // A response arriving with the redirect is simply discarded;
          // otherwise the stale one is still coming and must be dropped.
          if (!imem_resp_valid) begin
            w_state_nxt = S_WAIT;
            w_drop_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      // Decode consumed the current entry and nothing new arrives: bubble.
      if (!stall) begin
        w_if_valid_nxt = 1'b0;
        w_if_instr_nxt = NOP_INSTR;
      end
      case (r_state)
        S_ISSUE: begin
          if (imem_req_ready) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = S_ISSUE;
            end else if (w_can_load) begin
              w_load_en = 1'b1;
            end else begin
              w_buf_nxt   = imem_resp_data;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_load_en   = 1'b1;
            w_load_data = r_buf;
          end
        end
        default: begin
          w_state_nxt = S_ISSUE;
        end
      endcase
      if (w_load_en) begin
        w_if_valid_nxt = 1'b1;
        w_if_instr_nxt = w_load_data;
        w_if_pc4_nxt   = w_pc_plus4;
        w_pc_nxt       = w_pc_plus4;
        w_state_nxt    = S_ISSUE;
      end
    end
  end

  // State, PC and IF/ID register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ISSUE;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_buf      <= NOP_INSTR;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      r_if_pc4   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_buf      <= w_buf_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc4   <= w_if_pc4_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;

  // Count every real instruction written into IF/ID; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_load_en) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  // No performance counter in this build.
`endif

  // Request is only presented in ISSUE and never while reset is asserted.
  assign imem_req_valid = (r_state == S_ISSUE) & rst_n;
  assign imem_req_addr  = r_pc;
  assign if_id_valid    = r_if_valid;
  assign if_id_instr    = r_if_instr;
  assign if_id_pc4      = r_if_pc4;
  assign if_id_op       = r_if_instr[31:26];
  assign if_id_funct    = r_if_instr[5:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed, table-driven bench for fetch_stage, plus hand-written
//            sequences for reset-during-WAIT and PC wrap from a high RESET_PC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        stall;
  logic        br;
  logic [31:0] bt;
  logic        jmp;
  logic [31:0] jt;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  if_op;
  logic [5:0]  if_funct;

  logic        rst1_n;
  logic        req_valid1;
  logic        req_ready1;
  logic [31:0] req_addr1;
  logic        resp_valid1;
  logic [31:0] resp_data1;
  logic        if_valid1;
  logic [31:0] if_instr1;
  logic [31:0] if_pc41;
  logic [5:0]  if_op1;
  logic [5:0]  if_funct1;

`ifdef FETCH_PERF_EN
  logic [31:0] fcount;
  logic [31:0] fcount1;
`endif

  int n_total = 0;
  int n_pass  = 0;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .stall(stall), .branch_taken(br), .branch_target(bt),
    .jump(jmp), .jump_target(jt),
    .if_id_valid(if_valid), .if_id_instr(if_instr), .if_id_pc4(if_pc4),
    .if_id_op(if_op), .if_id_funct(if_funct)
`ifdef FETCH_PERF_EN
    , .fetch_count(fcount)
`endif
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0)) dut_wrap (
    .clk(clk), .rst_n(rst1_n),
    .imem_req_valid(req_valid1), .imem_req_ready(req_ready1), .imem_req_addr(req_addr1),
    .imem_resp_valid(resp_valid1), .imem_resp_data(resp_data1),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .jump(1'b0), .jump_target(32'h0),
    .if_id_valid(if_valid1), .if_id_instr(if_instr1), .if_id_pc4(if_pc41),
    .if_id_op(if_op1), .if_id_funct(if_funct1)
`ifdef FETCH_PERF_EN
    , .fetch_count(fcount1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] data;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic ready, input logic rv, input logic [31:0] data,
                              input logic st, input logic b, input logic [31:0] btg,
                              input logic j, input logic [31:0] jtg,
                              input logic e_rqv, input logic [31:0] e_addr,
                              input logic e_v, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.ready = ready; v.rv = rv; v.data = data; v.stall = st;
    v.br = b; v.bt = btg; v.j = j; v.jt = jtg;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_v = e_v;
    v.e_instr = e_instr; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  initial begin
    logic [31:0] ei;
    rst_n = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    stall = 1'b0; br = 1'b0; bt = '0; jmp = 1'b0; jt = '0;
    rst1_n = 1'b0; req_ready1 = 1'b0; resp_valid1 = 1'b0; resp_data1 = '0;

    //         rdy rv data          st br bt          j  jt       | rqv addr        v  instr         pc4
    vecs[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'h0,   0, 32'h0,        32'h0);
    vecs[1]  = mk(0, 1, 32'h20080005, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h0);
    vecs[2]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'h4,   1, 32'h20080005, 32'h4);
    vecs[3]  = mk(0, 1, 32'h8D090004, 0, 0, 32'h0,    0, 32'h0,   0, 32'h4,   0, 32'h0,        32'h4);
    vecs[4]  = mk(1, 0, 32'h0,        1, 0, 32'h0,    0, 32'h0,   1, 32'h8,   1, 32'h8D090004, 32'h8);
    vecs[5]  = mk(0, 1, 32'hAC0A0008, 1, 0, 32'h0,    0, 32'h0,   0, 32'h8,   1, 32'h8D090004, 32'h8);
    vecs[6]  = mk(1, 0, 32'h0,        1, 0, 32'h0,    0, 32'h0,   0, 32'h8,   1, 32'h8D090004, 32'h8);
    vecs[7]  = mk(1, 0, 32'h0,        1, 0, 32'h0,    0, 32'h0,   0, 32'h8,   1, 32'h8D090004, 32'h8);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   0, 32'h8,   1, 32'h8D090004, 32'h8);
    vecs[9]  = mk(1, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'hC,   1, 32'hAC0A0008, 32'hC);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h40,  0, 32'hC,   0, 32'h0,        32'hC);
    vecs[11] = mk(0, 1, 32'h11111111, 0, 0, 32'h0,    0, 32'h0,   0, 32'h40,  0, 32'h0,        32'hC);
    vecs[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'h40,  0, 32'h0,        32'hC);
    vecs[13] = mk(1, 0, 32'h0,        0, 1, 32'h100,  1, 32'h80,  1, 32'h40,  0, 32'h0,        32'hC);
    vecs[14] = mk(0, 1, 32'h22222222, 0, 0, 32'h0,    0, 32'h0,   0, 32'h80,  0, 32'h0,        32'hC);
    vecs[15] = mk(1, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'h80,  0, 32'h0,        32'hC);
    vecs[16] = mk(0, 1, 32'h3C010010, 1, 0, 32'h0,    0, 32'h0,   0, 32'h80,  0, 32'h0,        32'hC);
    vecs[17] = mk(0, 0, 32'h0,        1, 1, 32'h103,  0, 32'h0,   1, 32'h84,  1, 32'h3C010010, 32'h84);
    vecs[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'h100, 0, 32'h0,        32'h84);
    vecs[19] = mk(1, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'h100, 0, 32'h0,        32'h84);
    vecs[20] = mk(0, 1, 32'h00851020, 0, 0, 32'h0,    0, 32'h0,   0, 32'h100, 0, 32'h0,        32'h84);
    vecs[21] = mk(1, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,   1, 32'h104, 1, 32'h00851020, 32'h104);

    // Reset state while rst_n is low.
    repeat (2) @(negedge clk);
    #1;
    chk("reset rqv",   {31'b0, req_valid}, 32'h0);
    chk("reset addr",  req_addr, 32'h0);
    chk("reset valid", {31'b0, if_valid}, 32'h0);
    chk("reset instr", if_instr, 32'h0);
    chk("reset pc4",   if_pc4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      req_ready = vecs[i].ready; resp_valid = vecs[i].rv; resp_data = vecs[i].data;
      stall = vecs[i].stall; br = vecs[i].br; bt = vecs[i].bt;
      jmp = vecs[i].j; jt = vecs[i].jt;
      #1;
      ei = vecs[i].e_instr;
      chk($sformatf("row%0d rqv", i),   {31'b0, req_valid}, {31'b0, vecs[i].e_rqv});
      chk($sformatf("row%0d addr", i),  req_addr, vecs[i].e_addr);
      chk($sformatf("row%0d valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_v});
      chk($sformatf("row%0d instr", i), if_instr, ei);
      chk($sformatf("row%0d pc4", i),   if_pc4, vecs[i].e_pc4);
      chk($sformatf("row%0d op", i),    {26'b0, if_op}, {26'b0, ei[31:26]});
      chk($sformatf("row%0d funct", i), {26'b0, if_funct}, {26'b0, ei[5:0]});
      @(negedge clk);
    end

`ifdef FETCH_PERF_EN
    chk("fetch_count after table", fcount, 32'd5);
`endif

    // Reset asserted while a request is outstanding (state WAIT).
    req_ready = 1'b0; resp_valid = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset rqv",   {31'b0, req_valid}, 32'h0);
    chk("midreset addr",  req_addr, 32'h0);
    chk("midreset valid", {31'b0, if_valid}, 32'h0);
    chk("midreset instr", if_instr, 32'h0);
    chk("midreset pc4",   if_pc4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postreset rqv",  {31'b0, req_valid}, 32'h1);
    chk("postreset addr", req_addr, 32'h0);

    // PC wrap from RESET_PC = 0xFFFFFFFC.
    @(negedge clk);
    rst1_n = 1'b1; req_ready1 = 1'b1;
    #1;
    chk("wrap first rqv",  {31'b0, req_valid1}, 32'h1);
    chk("wrap first addr", req_addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    req_ready1 = 1'b0; resp_valid1 = 1'b1; resp_data1 = 32'h12345678;
    #1;
    chk("wrap wait rqv", {31'b0, req_valid1}, 32'h0);
    @(negedge clk);
    resp_valid1 = 1'b0;
    #1;
    chk("wrap valid", {31'b0, if_valid1}, 32'h1);
    chk("wrap instr", if_instr1, 32'h12345678);
    chk("wrap pc4",   if_pc41, 32'h0);
    chk("wrap next addr", req_addr1, 32'h0);
    chk("wrap next rqv",  {31'b0, req_valid1}, 32'h1);
`ifdef FETCH_PERF_EN
    chk("wrap fetch_count", fcount1, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
